// File: rtl/cache_controller_param_pkg.sv
// Shared types and geometry helpers for the parametrised direct-mapped cache.
package cache_param_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  function automatic int unsigned clog2u(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned off_w(input int unsigned words_per_line);
    return clog2u(words_per_line);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return clog2u(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_width,
                                        input int unsigned num_lines,
                                        input int unsigned words_per_line);
    return addr_width - idx_w(num_lines) - off_w(words_per_line);
  endfunction

endpackage

// File: rtl/cache_controller_param_line_array.sv
// Valid/tag/data storage with combinational lookup, line refill and word update.
module cache_line_array
  import cache_param_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned ADDR_WIDTH     = 10,
  parameter  int unsigned WORDS_PER_LINE = 4,
  parameter  int unsigned NUM_LINES      = 32,
  localparam int unsigned OFF_W          = off_w(WORDS_PER_LINE),
  localparam int unsigned IDX_W          = idx_w(NUM_LINES),
  localparam int unsigned TAG_W          = tag_w(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE),
  localparam int unsigned LINE_W         = DATA_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      idx,
  input  logic [TAG_W-1:0]      tag,
  input  logic [OFF_W-1:0]      off,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] rd_word,
  input  logic                  fill_en,
  input  logic [LINE_W-1:0]     fill_line,
  input  logic                  upd_en,
  input  logic [DATA_WIDTH-1:0] upd_data
);

  logic [NUM_LINES-1:0]                           valid;
  logic [TAG_W-1:0]                               tag_mem  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]      data_mem [NUM_LINES];

  assign hit     = valid[idx] && (tag_mem[idx] == tag);
  assign rd_word = data_mem[idx][off];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= fill_line;
    end else if (upd_en) begin
      data_mem[idx][off] <= upd_data;
    end
  end

endmodule

// File: rtl/cache_controller_param.sv
// Direct-mapped write-through, no-write-allocate cache controller.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module cache_controller_param
  import cache_param_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned ADDR_WIDTH     = 10,
  parameter  int unsigned WORDS_PER_LINE = 4,
  parameter  int unsigned NUM_LINES      = 32,
  localparam int unsigned OFF_W          = off_w(WORDS_PER_LINE),
  localparam int unsigned IDX_W          = idx_w(NUM_LINES),
  localparam int unsigned TAG_W          = tag_w(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE),
  localparam int unsigned LINE_W         = DATA_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  input  logic                  mem_wack
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  state_t                  state, state_nx;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    fill_en, upd_en;
  logic [OFF_W-1:0]        a_off;
  logic [IDX_W-1:0]        a_idx;
  logic [TAG_W-1:0]        a_tag;

  assign a_off = addr[OFF_W-1:0];
  assign a_idx = addr[OFF_W +: IDX_W];
  assign a_tag = addr[ADDR_WIDTH-1 -: TAG_W];

  cache_line_array #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .NUM_LINES      (NUM_LINES)
  ) u_lines (
    .clk       (clk),
    .reset     (reset),
    .idx       (a_idx),
    .tag       (a_tag),
    .off       (a_off),
    .hit       (hit),
    .rd_word   (rd_word),
    .fill_en   (fill_en),
    .fill_line (mem_rdata),
    .upd_en    (upd_en),
    .upd_data  (wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_en   = 1'b0;
    upd_en    = 1'b0;
    case (state)
      IDLE: begin
        if (we) begin
          stall    = 1'b1;
          state_nx = WRITE;
        end else if (re) begin
          if (hit) begin
            rdata = rd_word;
          end else begin
            stall    = 1'b1;
            state_nx = REFILL;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_rvalid) begin
          fill_en  = 1'b1;
          state_nx = IDLE;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        stall     = !mem_wack;
        if (mem_wack) begin
          upd_en   = hit;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // State is already IDLE under reset; this also silences a request still held on the inputs.
    if (reset) begin
      stall     = 1'b0;
      rdata     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_en   = 1'b0;
      upd_en    = 1'b0;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic rd_hit, rd_miss;

  assign rd_hit  = (state == IDLE) && re && !we && hit;
  assign rd_miss = (state == IDLE) && re && !we && !hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit  && (hit_count  != '1)) hit_count  <= hit_count + 32'd1;
      if (rd_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller_param.sv
// Randomised bench for cache_controller_param against a line-presence/memory reference model.
module tb_cache_controller_param;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned WPL = 4;
  localparam int unsigned NL  = 32;
  localparam int unsigned OW  = 2;
  localparam int unsigned IW  = 5;
  localparam int unsigned TW  = AW - IW - OW;
  localparam int unsigned LW  = DW * WPL;

  logic          clk = 1'b0;
  logic          reset;
  logic          re, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_rvalid, mem_wack;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]   hit_count, miss_count;
`endif

  cache_controller_param #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .WORDS_PER_LINE (WPL),
    .NUM_LINES      (NL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .re         (re),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wack   (mem_wack)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: backing memory per word, plus which line address each cache slot holds.
  logic [DW-1:0] mem [1 << AW];
  bit            m_valid [NL];
  logic [TW-1:0] m_tag [NL];
  int unsigned   n_vec, n_bad;
  int unsigned   exp_hits, exp_misses;

  assert property (@(posedge clk) disable iff (reset) stall |=> $stable(addr))
    else begin
      n_bad++;
      $display("FAIL addr_stable addr changed while stalled");
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [AW-1:0] a);
    int unsigned i;
    i = (a >> OW) % NL;
    return m_valid[i] && (m_tag[i] == a[AW-1 -: TW]);
  endfunction

  task automatic do_read(input logic [AW-1:0] a, input int unsigned lat);
    bit h, done, seen;
    int unsigned stalls, reqc, i;
    logic [AW-1:0] la;
    h = model_hit(a);
    la = a;
    la[OW-1:0] = '0;
    done = 0; seen = 0; stalls = 0; reqc = 0;
    re = 1'b1; we = 1'b0; addr = a;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        stalls++;
        if (mem_req) begin
          if (!seen) begin
            check("rd_mem_addr", mem_addr, la);
            check("rd_mem_we", mem_we, 0);
            seen = 1;
          end
          reqc++;
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        if (reqc == lat) begin
          for (int w = 0; w < WPL; w++) mem_rdata[w*DW +: DW] = mem[la + AW'(w)];
          mem_rvalid = 1'b1;
          reqc++;
        end
      end
    end
    if (!done) begin
      check("rd_timeout", 0, 1);
    end else begin
      check("rd_stall_cycles", stalls, h ? 0 : lat + 2);
      check("rd_data", rdata, mem[a]);
      check("rd_req_idle", mem_req, 0);
      i = (a >> OW) % NL;
      m_valid[i] = 1;
      m_tag[i]   = a[AW-1 -: TW];
      exp_hits++;
      if (!h) exp_misses++;
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int unsigned lat);
    bit done, seen;
    int unsigned stalls, reqc;
    done = 0; seen = 0; stalls = 0; reqc = 0;
    re = 1'($urandom_range(0, 1)); we = 1'b1; addr = a; wdata = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (mem_req) begin
        if (!seen) begin
          check("wr_mem_we", mem_we, 1);
          check("wr_mem_addr", mem_addr, a);
          check("wr_mem_wdata", mem_wdata, d);
          seen = 1;
        end
        reqc++;
      end
      if (!stall) begin
        done = 1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        mem_wack = 1'b0;
        if (reqc == lat) begin
          mem_wack = 1'b1;
          reqc++;
        end
      end
    end
    if (!done) check("wr_timeout", 0, 1);
    else       check("wr_stall_cycles", stalls, lat + 1);
    mem[a] = d;
    @(posedge clk); #1;
    mem_wack = 1'b0;
  endtask

  task automatic go_idle(input int unsigned n);
    re = 1'b0; we = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_stall", stall, 0);
      check("idle_req", mem_req, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic stray_pulses();
    re = 1'b0; we = 1'b0;
    mem_rdata  = {WPL{32'hDEAD_BEEF}};
    mem_rvalid = 1'b1;
    mem_wack   = 1'b1;
    @(negedge clk);
    check("stray_req", mem_req, 0);
    check("stray_stall", stall, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
  endtask

  task automatic check_counters();
`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    @(posedge clk); #1;
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    bit aborted;
    n_vec = 0; n_bad = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    model_reset();
    reset = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    #1;
    re = 1'b1; addr = 10'h085;
    #1;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    re = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_counters();

    do_read(10'h085, 3);
    do_read(10'h086, 0);
    do_write(10'h085, 32'hCAFE_F00D, 2);
    do_read(10'h085, 0);
    do_write(10'h3F0, 32'h1234_5678, 1);
    do_read(10'h3F0, 2);
    do_read(10'h004, 2);
    do_read(10'h084, 1);
    do_read(10'h004, 1);
    do_read(10'h07F, 1);
    do_read(10'h000, 1);
    do_read(10'h07F, 0);
    stray_pulses();
    go_idle(1);
    check_counters();

    // Abandon a refill with reset while the request is still presented.
    re = 1'b1; we = 1'b0; addr = 10'h2A8;
    aborted = 0;
    for (int k = 0; k < 20 && !aborted; k++) begin
      @(negedge clk);
      if (mem_req) aborted = 1;
    end
    check("mid_refill_req_seen", aborted, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0; re = 1'b0;
    stray_pulses();
    check_counters();
    do_read(10'h2A8, 2);
    do_read(10'h085, 1);

    for (int n = 0; n < 300; n++) begin
      ra = {TW'($urandom_range(0, 3)), IW'($urandom_range(0, 7) == 7 ? NL - 1 : $urandom_range(0, 6)),
            OW'($urandom_range(0, WPL - 1))};
      case ($urandom_range(0, 5))
        0, 1, 2: do_read(ra, $urandom_range(0, 4));
        3:       do_write(ra, $urandom, $urandom_range(0, 4));
        4:       go_idle($urandom_range(1, 2));
        default: stray_pulses();
      endcase
    end
    go_idle(1);
    check_counters();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
